// File: rtl/clksel_req.sv
// clksel_req: initiator side of the CPU clock-switch handshake.
// Decodes each CPU access and asks the clock controller for the fast or slow clock.
// While a switch is in flight the CPU is stalled with rdy.
// After the last host access the slow clock is held for SLOW_HOLD CPU cycles.
//
// Ports:
//   hsclk_in       free-running high-speed clock (all flops on posedge)
//   rst_b          asynchronous active-low reset
//   cpuclk_in      CPU clock, sampled as data to find CPU cycle boundaries
//   addr[23:0]     CPU bank/address
//   vda, vpa       valid data / program address
//   map_ram        1: bank 0 is local RAM except pages FC..FE
//   hsclk_selected acknowledge from the clock controller (asynchronous)
//   hsclk_sel      registered fast-clock request
//   rdy            CPU ready (0 = stall)
//   slow_active    1 while in SLOW_REQ or SLOW
//   switch_err     sticky handshake-timeout flag
module clksel_req #(
  parameter int unsigned SLOW_HOLD  = 4,
  parameter int unsigned SW_TIMEOUT = 1023
) (
  input  logic        hsclk_in,
  input  logic        rst_b,
  input  logic        cpuclk_in,
  input  logic [23:0] addr,
  input  logic        vda,
  input  logic        vpa,
  input  logic        map_ram,
  input  logic        hsclk_selected,
  output logic        hsclk_sel,
  output logic        rdy,
  output logic        slow_active,
  output logic        switch_err
);

  typedef enum logic [1:0] {StFast, StSlowReq, StSlow, StFastReq} state_e;

  localparam logic [7:0]  HoldInit = 8'(SLOW_HOLD);
  localparam logic [15:0] ToMax    = 16'(SW_TIMEOUT);

  state_e      r_state;
  logic        r_sel;
  logic [7:0]  r_hold;
  logic [15:0] r_to_cnt;
  logic        r_err;
  logic        r_ack_meta, r_ack_s;
  logic        r_cpu_meta, r_cpu_s, r_cpu_d;

  logic w_valid, w_host_hit, w_cyc_stb, w_in_req;
  logic w_unused_addr;

  assign w_valid    = vda | vpa;
  assign w_host_hit = w_valid & ((addr[23:16] == 8'hFF) |
                                 ((addr[23:16] == 8'h00) &
                                  (!map_ram | (addr[15:8] >= 8'hFC && addr[15:8] <= 8'hFE))));
  assign w_unused_addr = ^addr[7:0];

  // One pulse per CPU cycle, on the rising edge of the synchronized CPU clock.
  assign w_cyc_stb = r_cpu_s & ~r_cpu_d;
  assign w_in_req  = (r_state == StSlowReq) || (r_state == StFastReq);

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_cpu_meta <= 1'b0;
      r_cpu_s    <= 1'b0;
      r_cpu_d    <= 1'b0;
    end else begin
      r_ack_meta <= hsclk_selected;
      r_ack_s    <= r_ack_meta;
      r_cpu_meta <= cpuclk_in;
      r_cpu_s    <= r_cpu_meta;
      r_cpu_d    <= r_cpu_s;
    end
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= StSlow;
      r_sel    <= 1'b0;
      r_hold   <= HoldInit;
      r_to_cnt <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      // Handshake watchdog: saturates at the limit, flag is sticky until reset.
      if (w_in_req && (r_to_cnt != ToMax)) begin
        r_to_cnt <= r_to_cnt + 16'd1;
        if (r_to_cnt == ToMax - 16'd1) r_err <= 1'b1;
      end
      unique case (r_state)
        StFast: begin
          if (w_host_hit) begin
            r_state  <= StSlowReq;
            r_sel    <= 1'b0;
            r_to_cnt <= 16'd0;
          end
        end
        StSlowReq: begin
          if (!r_ack_s) begin
            r_state <= StSlow;
            r_hold  <= HoldInit;
          end
        end
        StSlow: begin
          if (w_cyc_stb) begin
            if (w_host_hit) begin
              r_hold <= HoldInit;
            end else if (w_valid) begin
              if (r_hold == 8'd1) begin
                r_state  <= StFastReq;
                r_sel    <= 1'b1;
                r_to_cnt <= 16'd0;
              end
              if (r_hold != 8'd0) r_hold <= r_hold - 8'd1;
            end
          end
        end
        StFastReq: begin
          // No abort: a host access here waits until FAST is reached.
          if (r_ack_s) r_state <= StFast;
        end
      endcase
    end
  end

  assign hsclk_sel   = r_sel;
  assign slow_active = (r_state == StSlowReq) || (r_state == StSlow);
  assign switch_err  = r_err;
  assign rdy         = !(w_in_req || ((r_state == StFast) && w_host_hit));

endmodule

// File: tb/tb_clksel_req.sv
// Self-checking bench for clksel_req: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the switching rules.
module tb_clksel_req;

  localparam int SlowHold  = 4;
  localparam int SwTimeout = 20;

  localparam int MFast    = 0;
  localparam int MSlowReq = 1;
  localparam int MSlow    = 2;
  localparam int MFastReq = 3;

  logic        hsclk_in = 1'b0;
  logic        rst_b = 1'b1;
  logic        cpuclk_in = 1'b0;
  logic [23:0] addr = 24'h010000;
  logic        vda = 1'b0;
  logic        vpa = 1'b0;
  logic        map_ram = 1'b0;
  logic        hsclk_selected = 1'b0;
  logic        hsclk_sel, rdy, slow_active, switch_err;

  clksel_req #(
    .SLOW_HOLD (SlowHold),
    .SW_TIMEOUT(SwTimeout)
  ) dut (
    .hsclk_in      (hsclk_in),
    .rst_b         (rst_b),
    .cpuclk_in     (cpuclk_in),
    .addr          (addr),
    .vda           (vda),
    .vpa           (vpa),
    .map_ram       (map_ram),
    .hsclk_selected(hsclk_selected),
    .hsclk_sel     (hsclk_sel),
    .rdy           (rdy),
    .slow_active   (slow_active),
    .switch_err    (switch_err)
  );

  always #5 hsclk_in = ~hsclk_in;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int       m_mode;
  int       m_hold;
  int       m_wait;
  bit       m_err;
  bit [1:0] m_ack_hist;  // [1] is the synchronized acknowledge
  bit [2:0] m_cpu_hist;  // CPU clock delay line; cycle starts where [1] & ~[2]

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic bit is_host(input logic [23:0] a, input bit valid, input bit mr);
    int bank = int'(a[23:16]);
    int page = int'(a[15:8]);
    if (!valid) return 1'b0;
    if (bank == 255) return 1'b1;
    if (bank == 0) return !mr || (page >= 252 && page <= 254);
    return 1'b0;
  endfunction

  function automatic bit is_req(input int m);
    return (m == MSlowReq) || (m == MFastReq);
  endfunction

  function automatic bit m_sel();
    return (m_mode == MFast) || (m_mode == MFastReq);
  endfunction

  function automatic bit m_slow();
    return (m_mode == MSlow) || (m_mode == MSlowReq);
  endfunction

  function automatic bit m_rdy();
    if (is_req(m_mode)) return 1'b0;
    if (m_mode == MFast && is_host(addr, vda | vpa, map_ram)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = MSlow;
    m_hold = SlowHold;
    m_wait = 0;
    m_err = 1'b0;
    m_ack_hist = '0;
    m_cpu_hist = '0;
  endtask

  // One hsclk_in edge, using the inputs as they were at that edge.
  task automatic model_edge();
    bit valid, host, ack_now, new_cycle;
    int nxt;
    if (!rst_b) begin
      model_reset();
      return;
    end
    valid = vda | vpa;
    host = is_host(addr, valid, map_ram);
    ack_now = m_ack_hist[1];
    new_cycle = m_cpu_hist[1] && !m_cpu_hist[2];
    nxt = m_mode;
    if (is_req(m_mode) && m_wait < SwTimeout) begin
      m_wait++;
      if (m_wait == SwTimeout) m_err = 1'b1;
    end
    case (m_mode)
      MFast:    if (host) nxt = MSlowReq;
      MSlowReq: if (!ack_now) begin nxt = MSlow; m_hold = SlowHold; end
      MSlow: begin
        if (new_cycle && valid) begin
          if (host) m_hold = SlowHold;
          else if (m_hold == 1) nxt = MFastReq;
          else if (m_hold > 0) m_hold--;
        end
      end
      default:  if (ack_now) nxt = MFast;
    endcase
    if (is_req(nxt) && !is_req(m_mode)) m_wait = 0;
    m_mode = nxt;
    m_ack_hist = {m_ack_hist[0], hsclk_selected};
    m_cpu_hist = {m_cpu_hist[1:0], cpuclk_in};
  endtask

  task automatic tick();
    @(posedge hsclk_in);
    #1;
    model_edge();
    check_eq("hsclk_sel", 32'(hsclk_sel), 32'(m_sel()));
    check_eq("slow_active", 32'(slow_active), 32'(m_slow()));
    check_eq("switch_err", 32'(switch_err), 32'(m_err));
  endtask

  task automatic settle();
    #1;
    check_eq("rdy", 32'(rdy), 32'(m_rdy()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  // One CPU cycle: two hsclk periods high, two low; the access is held throughout.
  task automatic cpu_cycle(input logic [23:0] a, input bit v);
    addr = a;
    vda = v;
    vpa = 1'b0;
    cpuclk_in = 1'b1;
    run(2);
    cpuclk_in = 1'b0;
    run(2);
  endtask

  initial begin
    model_reset();
    #2 rst_b = 1'b0;
    #1;
    check_eq("reset_sel", 32'(hsclk_sel), 32'd0);
    check_eq("reset_slow", 32'(slow_active), 32'd1);
    check_eq("reset_err", 32'(switch_err), 32'd0);
    check_eq("reset_rdy", 32'(rdy), 32'd1);
    run(2);
    rst_b = 1'b1;
    run(3);

    // Four valid non-host cycles from reset request the fast clock.
    for (int i = 0; i < 4; i++) cpu_cycle(24'h010000, 1'b1);
    check_eq("fast_req_sel", 32'(hsclk_sel), 32'd1);
    check_eq("fast_req_rdy", 32'(rdy), 32'd0);
    hsclk_selected = 1'b1;
    run(2);
    check_eq("ack_sync_rdy", 32'(rdy), 32'd0);
    run(1);
    check_eq("fast_rdy", 32'(rdy), 32'd1);

    // Host access in FAST: stall now, drop the request on the next edge.
    addr = 24'hFF1234;
    vda = 1'b1;
    #1;
    check_eq("host_stall", 32'(rdy), 32'd0);
    tick();
    check_eq("slow_req_sel", 32'(hsclk_sel), 32'd0);
    hsclk_selected = 1'b0;
    run(3);
    check_eq("slow_rdy", 32'(rdy), 32'd1);
    check_eq("slow_active", 32'(slow_active), 32'd1);

    // A host access in the middle restarts the hold count.
    for (int i = 0; i < 3; i++) cpu_cycle(24'h020000, 1'b1);
    cpu_cycle(24'hFF0000, 1'b1);
    for (int i = 0; i < 3; i++) cpu_cycle(24'h020000, 1'b1);
    check_eq("hold_no_req", 32'(hsclk_sel), 32'd0);
    cpu_cycle(24'h020000, 1'b1);
    check_eq("hold_req", 32'(hsclk_sel), 32'd1);
    hsclk_selected = 1'b1;
    run(3);

    // Bank 0 decode depends on map_ram.
    map_ram = 1'b1;
    addr = 24'h00FE40;
    vda = 1'b1;
    #1;
    check_eq("map_fe40_host", 32'(rdy), 32'd0);
    addr = 24'h008000;
    #1;
    check_eq("map_8000_local", 32'(rdy), 32'd1);
    run(3);
    check_eq("map_stay_fast", 32'(hsclk_sel), 32'd1);
    map_ram = 1'b0;
    #1;
    check_eq("nomap_8000_host", 32'(rdy), 32'd0);
    tick();
    check_eq("nomap_switch", 32'(hsclk_sel), 32'd0);
    hsclk_selected = 1'b0;
    run(3);

    // Acknowledge withheld: watchdog fires at the limit, state holds.
    for (int i = 0; i < 4; i++) cpu_cycle(24'h010000, 1'b1);
    run(SwTimeout - 2);
    check_eq("to_before", 32'(switch_err), 32'd0);
    run(1);
    check_eq("to_at_limit", 32'(switch_err), 32'd1);
    run(5);
    check_eq("to_hold_sel", 32'(hsclk_sel), 32'd1);
    check_eq("to_hold_rdy", 32'(rdy), 32'd0);
    hsclk_selected = 1'b1;
    run(3);
    check_eq("late_ack_rdy", 32'(rdy), 32'd1);
    check_eq("err_sticky", 32'(switch_err), 32'd1);

    // Reset in SLOW_REQ returns everything to reset values at once.
    addr = 24'hFF0000;
    run(1);
    check_eq("pre_rst_req", 32'(slow_active), 32'd1);
    rst_b = 1'b0;
    hsclk_selected = 1'b0;
    model_reset();
    #1;
    check_eq("rst_sel", 32'(hsclk_sel), 32'd0);
    check_eq("rst_slow", 32'(slow_active), 32'd1);
    check_eq("rst_err", 32'(switch_err), 32'd0);
    check_eq("rst_rdy", 32'(rdy), 32'd1);
    run(2);
    rst_b = 1'b1;
    run(2);

    // Randomized traffic with a clock controller that answers after random delays.
    for (int i = 0; i < 3000; i++) begin
      int kind;
      if ($urandom_range(0, 1) == 0) cpuclk_in = ~cpuclk_in;
      kind = int'($urandom_range(0, 5));
      addr = 24'($urandom);
      if (kind == 0) addr[23:16] = 8'hFF;
      else if (kind == 1) addr[23:16] = 8'h00;
      else if (kind == 2) addr[23:8] = 16'h00FC + 16'($urandom_range(0, 3));
      vda = ($urandom_range(0, 3) != 0);
      vpa = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) vda = 1'b0;
      if ($urandom_range(0, 63) == 0) map_ram = ~map_ram;
      if (hsclk_selected != m_sel() && $urandom_range(0, 2) == 0) hsclk_selected = m_sel();
      if (!rst_b) rst_b = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        rst_b = 1'b0;
        hsclk_selected = 1'b0;
        model_reset();
      end
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
